// File: rtl/counter_ctrl.sv
// Load/decrement sequencer for the 4-bit down-counter: latches a count, strobes dec until zero, pulses done.
// Optional decrement prescaler enabled by defining CNT_CTRL_PRESCALE_EN (PRESCALE cycles per strobe).
module counter_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] count,
  input  logic             abort,
  input  logic             zero,
  output logic             latch,
  output logic [WIDTH-1:0] load_value,
  output logic             dec,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Illegal PRESCALE values below 1 are clamped so the tick logic stays well defined.
  localparam int PS = (PRESCALE < 1) ? 1 : PRESCALE;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] load_value_q;
  logic             latch_q, busy_q, done_q;
  logic             tick;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)     state_d = S_IDLE;
        else if (zero) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      load_value_q <= '0;
      latch_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= (state_d == S_LOAD);
      busy_q  <= (state_d == S_LOAD) || (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
      if ((state_q == S_IDLE) && start) load_value_q <= count;
    end
  end

`ifdef CNT_CTRL_PRESCALE_EN
  localparam int              PW   = (PS > 1) ? $clog2(PS) : 1;
  localparam logic [PW-1:0]   PMAX = PW'(PS - 1);

  logic [PW-1:0] presc_q;

  // LOAD always precedes RUN, so holding the counter at 0 outside RUN clears it on entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (state_q != S_RUN) begin
      presc_q <= '0;
    end else if (presc_q == PMAX) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign tick = (presc_q == PMAX);
`else
  // PS is at least 1, so this is a constant 1.
  assign tick = (PS > 0);
`endif

  assign dec        = (state_q == S_RUN) && !abort && !zero && tick;
  assign latch      = latch_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_value = load_value_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl driving a behavioural 4-bit down-counter.
module tb_counter_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] count;
  logic       abort;
  logic       zero;
  logic       latch;
  logic [3:0] load_value;
  logic       dec;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_err;

  counter_ctrl #(.WIDTH(4), .PRESCALE(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .count      (count),
    .abort      (abort),
    .zero       (zero),
    .latch      (latch),
    .load_value (load_value),
    .dec        (dec),
    .busy       (busy),
    .done       (done)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // downstream down-counter
  logic [3:0] cnt_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      cnt_q <= 4'd0;
    else if (latch) cnt_q <= load_value;
    else if (dec)   cnt_q <= cnt_q - 4'd1;
  end
  assign zero = (cnt_q == 4'd0);

  // driver tasks
  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // checks {latch,dec,busy,done} in the middle of the current cycle
  task automatic exp_cyc(input string tag, input logic l, input logic d, input logic b, input logic dn);
    @(negedge clock);
    chk(tag, {latch, dec, busy, done}, {l, d, b, dn});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    count = 4'd0;
    abort = 1'b0;

    // reset state
    exp_cyc("reset_outs", 0, 0, 0, 0);
    chk("reset_load_value", load_value, 4'd0);
    nxt(); reset = 1'b0;
    exp_cyc("idle_after_reset", 0, 0, 0, 0);

    // count=3: latch c1, dec c2-4, busy c1-5, done c6
    nxt(); start = 1'b1; count = 4'd3;
    exp_cyc("n3_c0", 0, 0, 0, 0);
    nxt(); start = 1'b0; count = 4'd0;
    exp_cyc("n3_c1", 1, 0, 1, 0);
    chk("n3_load_value", load_value, 4'd3);
    nxt(); exp_cyc("n3_c2", 0, 1, 1, 0);
    nxt(); exp_cyc("n3_c3", 0, 1, 1, 0);
    nxt(); exp_cyc("n3_c4", 0, 1, 1, 0);
    nxt(); exp_cyc("n3_c5", 0, 0, 1, 0);
    nxt(); exp_cyc("n3_c6", 0, 0, 0, 1);
    nxt(); exp_cyc("n3_c7", 0, 0, 0, 0);
    chk("n3_load_value_hold", load_value, 4'd3);

    // count=0: no dec, done in c3
    nxt(); start = 1'b1; count = 4'd0;
    exp_cyc("n0_c0", 0, 0, 0, 0);
    nxt(); start = 1'b0;
    exp_cyc("n0_c1", 1, 0, 1, 0);
    nxt(); exp_cyc("n0_c2", 0, 0, 1, 0);
    nxt(); exp_cyc("n0_c3", 0, 0, 0, 1);
    nxt(); exp_cyc("n0_c4", 0, 0, 0, 0);

    // count=5, abort in second RUN cycle, restart right after
    nxt(); start = 1'b1; count = 4'd5;
    exp_cyc("ab_c0", 0, 0, 0, 0);
    nxt(); start = 1'b0;
    exp_cyc("ab_c1", 1, 0, 1, 0);
    nxt(); exp_cyc("ab_c2", 0, 1, 1, 0);
    nxt(); abort = 1'b1;
    exp_cyc("ab_c3_abort", 0, 0, 1, 0);
    nxt(); abort = 1'b0; start = 1'b1; count = 4'd1;
    exp_cyc("ab_c4_idle", 0, 0, 0, 0);
    nxt(); start = 1'b0;
    exp_cyc("ab_c5_restart", 1, 0, 1, 0);
    chk("ab_load_value", load_value, 4'd1);
    nxt(); exp_cyc("ab_c6", 0, 1, 1, 0);
    nxt(); exp_cyc("ab_c7", 0, 0, 1, 0);
    nxt(); exp_cyc("ab_c8", 0, 0, 0, 1);
    nxt(); exp_cyc("ab_c9", 0, 0, 0, 0);

    // start held high, count=2: period 6; count outside IDLE must not be captured
    for (int i = 0; i < 12; i++) begin
      nxt();
      start = 1'b1;
      count = ((i % 6) == 0) ? 4'd2 : 4'hF;
      case (i % 6)
        0:       exp_cyc($sformatf("b2b_c%0d", i), 0, 0, 0, 0);
        1:       exp_cyc($sformatf("b2b_c%0d", i), 1, 0, 1, 0);
        2, 3:    exp_cyc($sformatf("b2b_c%0d", i), 0, 1, 1, 0);
        4:       exp_cyc($sformatf("b2b_c%0d", i), 0, 0, 1, 0);
        default: exp_cyc($sformatf("b2b_c%0d", i), 0, 0, 0, 1);
      endcase
      if (i > 0) chk($sformatf("b2b_load_value_c%0d", i), load_value, 4'd2);
    end
    nxt(); start = 1'b0; count = 4'd0;
    exp_cyc("b2b_end", 0, 0, 0, 0);

`ifdef CNT_CTRL_PRESCALE_EN
    // PRESCALE=4, count=2: dec in c5 and c9, done in c11
    nxt(); start = 1'b1; count = 4'd2;
    exp_cyc("ps_c0", 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      nxt(); start = 1'b0;
      exp_cyc($sformatf("ps_c%0d", c), c == 1, (c == 5) || (c == 9),
              (c >= 1) && (c <= 10), c == 11);
    end
`endif

    // reset in the middle of RUN
    nxt(); start = 1'b1; count = 4'd6;
    exp_cyc("rst_c0", 0, 0, 0, 0);
    nxt(); start = 1'b0;
    exp_cyc("rst_c1", 1, 0, 1, 0);
    nxt(); exp_cyc("rst_c2", 0, 1, 1, 0);
    nxt(); exp_cyc("rst_c3", 0, 1, 1, 0);
    nxt(); reset = 1'b1;
    exp_cyc("rst_c4_asserted", 0, 0, 0, 0);
    chk("rst_load_value", load_value, 4'd0);
    nxt(); reset = 1'b0;
    exp_cyc("rst_c5_released", 0, 0, 0, 0);
    nxt(); start = 1'b1; count = 4'd1;
    exp_cyc("rst_c6", 0, 0, 0, 0);
    nxt(); start = 1'b0;
    exp_cyc("rst_c7", 1, 0, 1, 0);
    nxt(); exp_cyc("rst_c8", 0, 1, 1, 0);
    nxt(); exp_cyc("rst_c9", 0, 0, 1, 0);
    nxt(); exp_cyc("rst_c10", 0, 0, 0, 1);
    nxt(); exp_cyc("rst_c11", 0, 0, 0, 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencer that drives the load/decrement side of the 4-bit down-counter and consumes its zero flag. On a host start request it loads a count into the counter and issues decrement strobes until zero is reported, then signals completion with a one-cycle done pulse. It sits between host control logic and the counter instance and owns the counter's `latch`, `in` and `dec` inputs.

## Interface
Parameters:
- `WIDTH`, default 4: width of the count path; must match the counter.
- `PRESCALE`, default 4: cycles per decrement strobe; only used when `CNT_CTRL_PRESCALE_EN` is defined; legal range ≥1.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  host request; sampled only in IDLE.
- `count`  in  WIDTH  number of decrements requested; captured with `start`.
- `abort`  in  1  cancel the operation in progress.
- `zero`  in  1  zero flag from the counter.
- `latch`  out  1  to the counter's latch input.
- `load_value`  out  WIDTH  to the counter's `in`; holds the captured count.
- `dec`  out  1  to the counter's decrement input.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset forces IDLE.
- IDLE: if `start` is high, capture `count` into `load_value` and go to LOAD. Otherwise stay in IDLE. `abort` is ignored in IDLE.
- LOAD: `latch`=1 for exactly one cycle. Next state is RUN, or IDLE if `abort` is high.
- RUN:
  - `abort` has top priority: go to IDLE, `dec`=0 in that cycle, no `done`.
  - Else if `zero`=1: go to DONE, `dec`=0.
  - Else stay in RUN with `dec`=tick. tick is a constant 1 unless prescaling is enabled (see Configuration).
- DONE: `done`=1 for one cycle, then go to IDLE. `start` is not accepted in DONE.
- `dec` is combinational from state, `zero`, `abort` and the tick. It is never high outside RUN and never high while `zero`=1.
- `latch` and `dec` are never high in the same cycle.
- `load_value` holds its value until the next accepted `start`.
- `count`=0: the operation completes with no `dec` strobes.
- Reset mid-operation: all outputs go low immediately. `load_value`=0. Any partial count left in the counter is not the controller's concern.

## Timing
- Reset values: `latch`=0, `dec`=0, `busy`=0, `done`=0, `load_value`=0, state IDLE.
- If `start` is high in cycle t (no prescale):
  - `latch`=1 in cycle t+1.
  - `busy`=1 in cycles t+1 through t+N+2.
  - `dec`=1 in cycles t+2 through t+N+1.
  - `zero` is seen in cycle t+N+2.
  - `done`=1 in cycle t+N+3.
- With N=0, `done` is high in cycle t+3.
- Earliest accepted restart: `start` in cycle t+N+4. Back-to-back throughput is N+4 cycles per operation.
- `abort` in cycle a during LOAD or RUN: `busy`=0 from a+1, and a new `start` is accepted in a+1.

## Configuration
- `CNT_CTRL_PRESCALE_EN` defined:
  - A prescale counter clears to 0 on entry to RUN and increments each RUN cycle, wrapping at PRESCALE−1.
  - tick=1 only when the prescale counter equals PRESCALE−1.
  - `dec` strobes fall in cycles t+1+k·PRESCALE, for k=1..N.
  - `done` is high in cycle t+3+N·PRESCALE.
  - PRESCALE=1 is cycle-identical to the non-prescaled build.
- `CNT_CTRL_PRESCALE_EN` undefined: no prescale counter exists, tick is always 1, and `PRESCALE` has no effect.

## Test plan
- Reset, then `start` with `count`=3 in cycle 0 (controller driving a real counter instance):
  - `latch` high in cycle 1.
  - `dec` high in cycles 2–4.
  - `done` high in cycle 6 only.
  - `busy` high in cycles 1–5.
- `start` with `count`=0: no `dec` strobes, `done` high in cycle 3.
- `count`=5, `abort` asserted in the second RUN cycle: `dec` low in the abort cycle, `busy` low from the next cycle, no `done`. A `start` in the following cycle is accepted.
- `start` held high continuously with `count`=2: operations complete every 6 cycles, and `start` is ignored during LOAD, RUN and DONE.
- Assert `reset` in the middle of RUN: all outputs go to 0 in the same cycle and `load_value`=0. After release, the controller is in IDLE.
- With `CNT_CTRL_PRESCALE_EN` and PRESCALE=4, `count`=2, `start` in cycle 0: `dec` high only in cycles 5 and 9, `done` high in cycle 11.
